// File: rtl/rs232rx_fifo_ctrl_if.sv
// Bus between the RS-232 receive FIFO controller and its neighbours.
// The bundle carries three groups of signals:
//   - Receiver strobe: rx_valid, rx_data
//   - CPU read port and control: enable, flush, pop, rd_data, empty, full,
//     count, threshold
//   - Status and interrupt: clear_status, irq_mask, overrun, idle, irq
// Modports:
//   - slave: used by the controller.
//   - master: used by whatever drives the controller (receiver, CPU glue,
//     or a bench).
interface rs232rx_fifo_ctrl_if #(
  parameter int fifo_log2 = 4
);
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 enable;
  logic                 flush;
  logic                 pop;
  logic [7:0]           rd_data;
  logic                 empty;
  logic                 full;
  logic [fifo_log2:0]   count;
  logic [fifo_log2:0]   threshold;
  logic                 clear_status;
  logic [2:0]           irq_mask;
  logic                 overrun;
  logic                 idle;
  logic                 irq;

  modport slave (
    input  rx_valid, rx_data, enable, flush, pop, threshold, clear_status, irq_mask,
    output rd_data, empty, full, count, overrun, idle, irq
  );

  modport master (
    output rx_valid, rx_data, enable, flush, pop, threshold, clear_status, irq_mask,
    input  rd_data, empty, full, count, overrun, idle, irq
  );
endinterface

// File: rtl/rs232rx_fifo_ctrl.sv
// Receive-side controller for the RS-232 receiver.
// Buffers received bytes in a 2^fifo_log2-entry FIFO and presents them on a
// pop-style read port. It keeps two sticky status flags:
//   - overrun: a byte was lost because the FIFO was full.
//   - idle: data is waiting and the line has been quiet for idle_cycles.
// Level, idle and overrun conditions are combined, under irq_mask, into one
// registered interrupt.
// Ports:
//   clock - system clock, all state on the rising edge
//   reset - asynchronous, active-high; clears all control state
//   bus   - rs232rx_fifo_ctrl_if.slave (receiver strobe, read port,
//           status, interrupt)
module rs232rx_fifo_ctrl #(
  parameter int fifo_log2   = 4,
  parameter int idle_cycles = 17360
) (
  input  logic                  clock,
  input  logic                  reset,
  rs232rx_fifo_ctrl_if.slave    bus
);

  localparam int                 DEPTH     = 1 << fifo_log2;
  localparam logic [fifo_log2:0] DEPTH_CNT = (fifo_log2 + 1)'(DEPTH);
  localparam logic [19:0]        IDLE_LOAD = 20'(idle_cycles);

  logic [7:0]           mem [DEPTH];
  logic [fifo_log2-1:0] wr_ptr;
  logic [fifo_log2-1:0] rd_ptr;
  logic [fifo_log2:0]   cnt;
  logic [fifo_log2:0]   cnt_next;
  logic [19:0]          timer;
  logic                 ovr;
  logic                 idl;
  logic                 irq_r;

  logic empty_w;
  logic full_w;
  logic pop_ok;
  logic push;
  logic pop_do;
  logic drop;
  logic timer_dec;
  logic idle_set;
  logic idle_clr;

  assign empty_w = (cnt == '0);
  assign full_w  = (cnt == DEPTH_CNT);
  assign pop_ok  = bus.pop & ~empty_w;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push    = bus.rx_valid & bus.enable & ~bus.flush & (~full_w | pop_ok);
  assign pop_do  = pop_ok & ~bus.flush;
  assign drop    = bus.rx_valid & bus.enable & ~bus.flush & full_w & ~pop_ok;

  always_comb begin
    cnt_next = cnt;
    if (bus.flush) begin
      cnt_next = '0;
    end else begin
      case ({push, pop_do})
        2'b10:   cnt_next = cnt + 1'b1;
        2'b01:   cnt_next = cnt - 1'b1;
        default: cnt_next = cnt;
      endcase
    end
  end

  // The timer only runs down while bytes are held and none is arriving.
  // Idle sets on the 1->0 step, unless this same cycle empties the FIFO.
  assign timer_dec = ~push & ~bus.flush & (cnt != '0) & (timer != '0);
  assign idle_set  = timer_dec & (timer == 20'd1) & (cnt_next != '0);
  assign idle_clr  = bus.clear_status | push | bus.flush | (cnt_next == '0);

  // Storage is data only: no reset, contents are meaningless while empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      timer  <= '0;
      ovr    <= 1'b0;
      idl    <= 1'b0;
      irq_r  <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (pop_do) rd_ptr <= rd_ptr + 1'b1;
      end

      cnt <= cnt_next;

      if (cnt_next == '0) begin
        timer <= '0;
      end else if (push) begin
        timer <= IDLE_LOAD;
      end else if (timer_dec) begin
        timer <= timer - 1'b1;
      end

      // Set beats a same-cycle clear on both sticky flags.
      if (drop) begin
        ovr <= 1'b1;
      end else if (bus.clear_status) begin
        ovr <= 1'b0;
      end

      if (idle_set) begin
        idl <= 1'b1;
      end else if (idle_clr) begin
        idl <= 1'b0;
      end

      // Built from the registered status, so irq trails it by one cycle.
      irq_r <= (bus.irq_mask[0] & (cnt >= bus.threshold) & (cnt != '0))
             | (bus.irq_mask[1] & idl)
             | (bus.irq_mask[2] & ovr);
    end
  end

  assign bus.rd_data = empty_w ? 8'h00 : mem[rd_ptr];
  assign bus.empty   = empty_w;
  assign bus.full    = full_w;
  assign bus.count   = cnt;
  assign bus.overrun = ovr;
  assign bus.idle    = idl;
  assign bus.irq     = irq_r;

endmodule
